// File: rtl/mmio_pkg.sv
// Shared types and constants for the picorv32 memory-mapped interconnect.
// Holds the transaction state encoding and small sizing/arithmetic helpers.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERROR  = 2'd3
    } mmio_state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;
    localparam int          DEFAULT_TIMEOUT  = 16;
    localparam int          DEFAULT_CNT_W    = $clog2(DEFAULT_TIMEOUT + 1);

    // Counter width able to hold TIMEOUT_CYCLES; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational address decoder: instruction fetches go to a fixed slave,
// data accesses to the lowest-index slave whose masked base matches.
module mmio_addr_match
    import mmio_pkg::*;
#(
    parameter int                           N_SLAVES    = 9,
    parameter int                           ADDR_WIDTH  = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {N_SLAVES{32'hFFFFFFFC}},
    parameter int                           INSTR_SLAVE = 0,
    parameter int                           SEL_W       = sel_width(N_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  instr,
    output logic [SEL_W-1:0]      sel_index,
    output logic                  hit
);

    logic [N_SLAVES-1:0] match_s;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_cmp
        assign match_s[i] = ((addr & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                             (BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH] &
                              ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end

    // Scanning downward leaves the lowest matching index, so it wins overlaps.
    function automatic logic [SEL_W-1:0] first_set(input logic [N_SLAVES-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    assign sel_index = instr ? SEL_W'(INSTR_SLAVE) : first_set(match_s);
    assign hit       = instr | (|match_s);

endmodule

// File: rtl/mmio_interconnect.sv
// picorv32 native bus to N-slave interconnect with per-transaction FSM,
// slave timeout and error reporting so the CPU can never hang on the bus.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int                             N_SLAVES       = 9,
    parameter int                             ADDR_WIDTH     = 32,
    parameter int                             DATA_WIDTH     = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS     = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS     = {N_SLAVES{32'hFFFFFFFC}},
    parameter int                             INSTR_SLAVE    = 0,
    parameter int                             TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0]          ERR_DATA       = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
    input  logic                           clk_in,
    input  logic                           reset_n_in,
    input  logic                           mem_valid,
    input  logic                           mem_instr,
    input  logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [3:0]                     mem_wstrb,
    output logic                           mem_ready,
    output logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [N_SLAVES-1:0]            slv_enable,
    output logic                           slv_write,
    output logic [3:0]                     slv_wstrb,
    output logic [ADDR_WIDTH-1:0]          slv_addr,
    output logic [DATA_WIDTH-1:0]          slv_wdata,
    input  logic [N_SLAVES-1:0]            slv_ready,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] slv_rdata,
    output logic                           bus_error,
    output logic [ADDR_WIDTH-1:0]          err_addr,
    output logic [15:0]                    err_count
);

    localparam int SEL_W = sel_width(N_SLAVES);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    mmio_state_e             state_r;
    logic [SEL_W-1:0]        sel_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [CNT_W-1:0]        cnt_r;

    logic [SEL_W-1:0]        sel_s;
    logic                    hit_s;
    logic [ADDR_WIDTH-1:0]   mask_sel_s;
    logic                    sel_ready_s;
    logic [DATA_WIDTH-1:0]   sel_rdata_s;
    logic                    timeout_s;

    mmio_addr_match #(
        .N_SLAVES    (N_SLAVES),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE_ADDRS  (BASE_ADDRS),
        .ADDR_MASKS  (ADDR_MASKS),
        .INSTR_SLAVE (INSTR_SLAVE),
        .SEL_W       (SEL_W)
    ) u_match (
        .addr      (mem_addr),
        .instr     (mem_instr),
        .sel_index (sel_s),
        .hit       (hit_s)
    );

    function automatic logic [N_SLAVES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_SLAVES-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign mask_sel_s  = ADDR_MASKS[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_ready_s = slv_ready[sel_r];
    assign sel_rdata_s = slv_rdata[sel_r*DATA_WIDTH +: DATA_WIDTH];
    assign timeout_s   = TMO_EN && (cnt_r == TMO_LAST);

    // Transaction FSM; every output is a register updated from this block.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r    <= IDLE;
            sel_r      <= '0;
            addr_r     <= '0;
            cnt_r      <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            slv_enable <= '0;
            slv_write  <= 1'b0;
            slv_wstrb  <= 4'h0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            bus_error  <= 1'b0;
            err_addr   <= '0;
            err_count  <= 16'h0000;
        end else begin
            mem_ready <= 1'b0;
            bus_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_valid) begin
                        sel_r     <= sel_s;
                        addr_r    <= mem_addr;
                        slv_write <= (mem_wstrb != 4'h0);
                        slv_wstrb <= mem_wstrb;
                        slv_wdata <= mem_wdata;
                        if (hit_s) begin
                            slv_addr   <= mem_addr & ~mask_sel_s;
                            slv_enable <= onehot(sel_s);
                            cnt_r      <= '0;
                            state_r    <= ACCESS;
                        end else begin
                            slv_addr  <= mem_addr;
                            mem_ready <= 1'b1;
                            bus_error <= 1'b1;
                            mem_rdata <= ERR_DATA;
                            err_addr  <= mem_addr;
                            err_count <= sat_inc16(err_count);
                            state_r   <= ERROR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Ready is tested first so a last-cycle response is not lost.
                    if (sel_ready_s) begin
                        mem_rdata  <= sel_rdata_s;
                        mem_ready  <= 1'b1;
                        slv_enable <= '0;
                        state_r    <= RESP;
                    end else if (timeout_s) begin
                        mem_rdata  <= ERR_DATA;
                        mem_ready  <= 1'b1;
                        bus_error  <= 1'b1;
                        err_addr   <= addr_r;
                        err_count  <= sat_inc16(err_count);
                        slv_enable <= '0;
                        state_r    <= ERROR;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                ERROR: begin
                    state_r <= IDLE;
                end
                default: begin
                    slv_enable <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed table-driven bench for mmio_interconnect with a 4-slave map,
// plus hand-written reset-during-access sequence.
module tb_mmio_interconnect;

    localparam int NS = 4;

    logic          clk_in;
    logic          reset_n_in;
    logic          mem_valid;
    logic          mem_instr;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [NS-1:0] slv_enable;
    logic          slv_write;
    logic [3:0]    slv_wstrb;
    logic [31:0]   slv_addr;
    logic [31:0]   slv_wdata;
    logic [NS-1:0] slv_ready;
    logic [NS*32-1:0] slv_rdata;
    logic          bus_error;
    logic [31:0]   err_addr;
    logic [15:0]   err_count;

    int checks;
    int failures;
    int exp_errs;

    mmio_interconnect #(
        .N_SLAVES       (NS),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .BASE_ADDRS     ({32'h00001000, 32'h10000000, 32'h00001000, 32'h00000000}),
        .ADDR_MASKS     ({32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFFF000, 32'hFFFFF000}),
        .INSTR_SLAVE    (0),
        .TIMEOUT_CYCLES (16),
        .ERR_DATA       (32'hDEADBEEF)
    ) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .slv_enable (slv_enable),
        .slv_write  (slv_write),
        .slv_wstrb  (slv_wstrb),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_ready  (slv_ready),
        .slv_rdata  (slv_rdata),
        .bus_error  (bus_error),
        .err_addr   (err_addr),
        .err_count  (err_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_lat;   // enable cycle (0-based) on which the slave answers
        logic        oth;       // non-selected slaves also drive ready
        logic [31:0] rdata;
        logic [3:0]  exp_en;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          lat;       // cycles after request edge where mem_ready is high
        int          encyc;     // number of cycles slv_enable is held
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic instr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int rdy_lat, input logic oth, input logic [31:0] rdata,
                                input logic [3:0] exp_en, input logic [31:0] exp_addr,
                                input logic exp_wr, input logic exp_err,
                                input logic [31:0] exp_rdata, input int lat, input int encyc);
        vec_t v;
        v.instr = instr;     v.addr = addr;         v.wdata = wdata;   v.wstrb = wstrb;
        v.rdy_lat = rdy_lat; v.oth = oth;           v.rdata = rdata;
        v.exp_en = exp_en;   v.exp_addr = exp_addr; v.exp_wr = exp_wr; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata; v.lat = lat;       v.encyc = encyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int  en_cyc;
        bit  done;
        en_cyc = 0;
        done   = 1'b0;
        @(negedge clk_in);
        mem_valid = 1'b1;
        mem_instr = v.instr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        slv_ready = '0;
        for (int i = 0; i < NS; i++) begin
            slv_rdata[i*32 +: 32] = v.exp_en[i] ? v.rdata : (32'hBAD00000 | 32'(i));
        end
        @(posedge clk_in);
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (k == 1) begin
                chk($sformatf("v%0d_enable", id), 32'(slv_enable), 32'(v.exp_en));
                if (v.exp_en != 4'h0) chk($sformatf("v%0d_slv_addr", id), slv_addr, v.exp_addr);
                chk($sformatf("v%0d_slv_write", id), 32'(slv_write), 32'(v.exp_wr));
                chk($sformatf("v%0d_slv_wstrb", id), 32'(slv_wstrb), 32'(v.wstrb));
                chk($sformatf("v%0d_slv_wdata", id), slv_wdata, v.wdata);
            end
            if (slv_enable != '0) en_cyc++;
            if (mem_ready) begin
                if (v.exp_err) exp_errs++;
                chk($sformatf("v%0d_latency", id), 32'(k), 32'(v.lat));
                chk($sformatf("v%0d_rdata", id), mem_rdata, v.exp_rdata);
                chk($sformatf("v%0d_bus_error", id), 32'(bus_error), 32'(v.exp_err));
                chk($sformatf("v%0d_err_count", id), 32'(err_count), 32'(exp_errs));
                if (v.exp_err) chk($sformatf("v%0d_err_addr", id), err_addr, v.addr);
                done = 1'b1;
            end
            slv_ready = '0;
            if (!done && slv_enable != '0) begin
                if (en_cyc - 1 == v.rdy_lat) slv_ready = v.exp_en;
                if (v.oth) slv_ready = slv_ready | ~v.exp_en;
            end
            @(posedge clk_in);
            if (done) break;
        end
        #1;
        mem_valid = 1'b0;
        slv_ready = '0;
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL v%0d_no_ready actual=none required=mem_ready", id);
        end
        chk($sformatf("v%0d_ready_pulse", id), 32'(mem_ready), 32'h0);
        chk($sformatf("v%0d_enable_cycles", id), 32'(en_cyc), 32'(v.encyc));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_errs   = 0;
        reset_n_in = 1'b0;
        mem_valid  = 1'b0;
        mem_instr  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'h0;
        slv_ready  = '0;
        slv_rdata  = '0;

        //            instr addr          wdata         wstrb lat oth rdata         en    off          wr   err   exp_rdata     lat enc
        vecs[0] = mk(1'b0, 32'h00001004, 32'h00000000, 4'h0, 0,  1'b0, 32'h12345678, 4'h2, 32'h004,   1'b0, 1'b0, 32'h12345678, 2,  1);
        vecs[1] = mk(1'b0, 32'h10000000, 32'h000000A5, 4'hF, 0,  1'b0, 32'h00000000, 4'h4, 32'h000,   1'b1, 1'b0, 32'h00000000, 2,  1);
        vecs[2] = mk(1'b1, 32'h00001004, 32'h00000000, 4'h0, 1,  1'b0, 32'hCAFE0001, 4'h1, 32'h004,   1'b0, 1'b0, 32'hCAFE0001, 3,  2);
        vecs[3] = mk(1'b0, 32'h20000000, 32'h00000000, 4'h0, 0,  1'b0, 32'h00000000, 4'h0, 32'h000,   1'b0, 1'b1, 32'hDEADBEEF, 1,  0);
        vecs[4] = mk(1'b0, 32'h00000FFC, 32'h00000000, 4'h0, 2,  1'b1, 32'h0BADF00D, 4'h1, 32'hFFC,   1'b0, 1'b0, 32'h0BADF00D, 4,  3);
        vecs[5] = mk(1'b0, 32'h10000002, 32'h00770000, 4'h4, 0,  1'b0, 32'h00000000, 4'h4, 32'h002,   1'b1, 1'b0, 32'h00000000, 2,  1);
        vecs[6] = mk(1'b0, 32'h10000004, 32'h11111111, 4'hF, 0,  1'b0, 32'h00000000, 4'h0, 32'h000,   1'b1, 1'b1, 32'hDEADBEEF, 1,  0);
        vecs[7] = mk(1'b0, 32'h00001008, 32'h00000000, 4'h0, 99, 1'b1, 32'h00000000, 4'h2, 32'h008,   1'b0, 1'b1, 32'hDEADBEEF, 17, 16);
        vecs[8] = mk(1'b0, 32'h0000100C, 32'h00000000, 4'h0, 15, 1'b0, 32'h5A5A5A5A, 4'h2, 32'h00C,   1'b0, 1'b0, 32'h5A5A5A5A, 17, 16);

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_enable", 32'(slv_enable), 32'h0);
        chk("rst_slv_bus", {slv_addr[15:0], slv_wdata[11:0], slv_wstrb}, 32'h0);
        chk("rst_errors", {err_count, 15'h0, bus_error}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        @(negedge clk_in);
        reset_n_in = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset asserted mid-ACCESS must abort with no completion.
        @(negedge clk_in);
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = 32'h00001010;
        mem_wstrb = 4'h0;
        slv_ready = '0;
        @(posedge clk_in);
        repeat (3) @(posedge clk_in);
        #1;
        chk("midrst_enable_before", 32'(slv_enable), 32'h2);
        #2;
        reset_n_in = 1'b0;
        #1;
        chk("midrst_enable", 32'(slv_enable), 32'h0);
        chk("midrst_ready", 32'(mem_ready), 32'h0);
        chk("midrst_err_count", 32'(err_count), 32'h0);
        mem_valid = 1'b0;
        exp_errs  = 0;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("postrst_no_ready", 32'(mem_ready), 32'h0);
        run_vec(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_interconnect.md
Name: mmio_interconnect

Overview:
- Parametrised memory-mapped interconnect between the picorv32 native memory bus and N peripheral slaves (rom, ram, io registers, spi, future blocks).
- Replaces hand-written per-address enable decoding and the shared, multiply-driven ready/rdata wiring.
- Address map is set by parameters. Each transaction is tracked by an FSM.
- Unmapped accesses and stalled slaves complete with an error response, so the CPU never hangs.

Parameters:
- N_SLAVES, 9, number of slave channels
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width
- BASE_ADDRS, {N_SLAVES{32'h0}}, packed N_SLAVES*ADDR_WIDTH vector; slice i is the base address of slave i
- ADDR_MASKS, {N_SLAVES{32'hFFFFFFFC}}, packed vector; slave i matches when (addr & mask_i) == (base_i & mask_i)
- INSTR_SLAVE, 0, slave index that receives every access with mem_instr=1, regardless of address
- TIMEOUT_CYCLES, 16, maximum number of cycles to wait for slave ready; 0 disables the timeout
- ERR_DATA, 32'hDEADBEEF, read data returned on an error

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous active-low reset
- mem_valid  input  1  CPU request valid
- mem_instr  input  1  request is an instruction fetch
- mem_addr  input  ADDR_WIDTH  CPU address
- mem_wdata  input  DATA_WIDTH  CPU write data
- mem_wstrb  input  4  byte write strobes; nonzero means write
- mem_ready  output  1  one-cycle completion pulse to the CPU
- mem_rdata  output  DATA_WIDTH  registered read data to the CPU
- slv_enable  output  N_SLAVES  one-hot slave select
- slv_write  output  1  registered (mem_wstrb != 0)
- slv_wstrb  output  4  registered strobes
- slv_addr  output  ADDR_WIDTH  registered address as (mem_addr & ~mask_sel); this is the slave offset
- slv_wdata  output  DATA_WIDTH  registered write data
- slv_ready  input  N_SLAVES  per-slave completion
- slv_rdata  input  N_SLAVES*DATA_WIDTH  per-slave read data
- bus_error  output  1  one-cycle pulse on an unmapped access or a timeout
- err_addr  output  ADDR_WIDTH  address of the most recent error
- err_count  output  16  saturating error counter

Behaviour:
- Reset values: all outputs are 0, the state is IDLE, and the timeout counter is 0. Reset is asynchronous and may occur mid-transaction; it aborts the transaction immediately and no mem_ready is issued.
- Decode:
  - If mem_instr=1, the target is INSTR_SLAVE.
  - Otherwise the target is the lowest-index slave whose masked compare matches; lower index wins on overlap.
  - If nothing matches, the access is unmapped.
- States IDLE, ACCESS, RESP, ERROR.
- IDLE:
  - On mem_valid=1 at an edge, latch addr, wdata, wstrb and the select.
  - Mapped access: go to ACCESS with slv_enable[sel]=1 from the next cycle.
  - Unmapped access: go to ERROR.
- ACCESS:
  - slv_enable stays one-hot and held, and the counter increments each cycle.
  - If slv_ready[sel]=1 at an edge, capture slv_rdata[sel] into mem_rdata, drop slv_enable, and go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, go to ERROR.
  - Ready wins over timeout on the same edge.
  - slv_ready from non-selected slaves is ignored.
- RESP: mem_ready=1 for exactly one cycle, then return to IDLE.
- ERROR:
  - mem_rdata=ERR_DATA, mem_ready=1 and bus_error=1 for one cycle.
  - err_addr is loaded and err_count increments, saturating at 16'hFFFF.
  - Then return to IDLE. Writes that end in ERROR are dropped.
- Latency (edges counted from the request edge E0):
  - Mapped access where the slave is ready on the first enable cycle: slv_enable rises after E0, ready is sampled at E1, mem_ready is high in the cycle after E1, and the transaction completes at E2.
  - Unmapped access: mem_ready is high in the cycle after E0.
- mem_valid must not start a new transaction while the state is not IDLE. A request that is still valid in the IDLE cycle immediately following RESP or ERROR is a new transaction; picorv32 drops mem_valid on the same edge.
- slv_enable is never multi-hot and is 0 outside ACCESS.
- The counter clears on entry to ACCESS.

Decomposition:
- Package mmio_pkg holds:
  - the state enum (IDLE/ACCESS/RESP/ERROR)
  - the default ERR_DATA constant
  - a counter-width constant derived via $clog2(TIMEOUT_CYCLES+1)
- Sub-module mmio_addr_match is purely combinational. It takes the address, mem_instr and the parameter vectors, and produces sel_index and the hit flag.

Test Plan:
- Map slave 0 at 0x0, slave 1 at 0x1000 (mask 0xFFFFF000). CPU read 0x1004 with slave 1 ready immediately and rdata 0x12345678 -> slv_enable=0b10, slv_addr=0x4, mem_ready one cycle later with mem_rdata=0x12345678, no bus_error.
- CPU write 0x10000000 with wdata 0xA5, wstrb 0xF to a slave at 0x10000000 (mask 0xFFFFFFFC) -> slv_write=1, slv_wdata=0xA5, exactly one mem_ready pulse.
- Instruction fetch at 0x1004 (mem_instr=1) -> routed to INSTR_SLAVE=0, not slave 1.
- Read 0x20000000 (unmapped) -> mem_ready and bus_error in the cycle after the request, mem_rdata=0xDEADBEEF, err_addr=0x20000000, err_count=1.
- With TIMEOUT_CYCLES=16, the slave never asserts ready -> slv_enable is held for 16 cycles, then ERROR and mem_ready; a slave ready arriving on the final cycle yields a normal RESP instead.
- Assert reset_n_in low during ACCESS -> slv_enable and mem_ready go 0 immediately; after release, a fresh read completes normally.
